// File: rtl/master_arb_link.sv
`default_nettype none
// ============================================================================
//  Module      : master_arb_link
//  Description : Master-side serial arbitration link endpoint. Serialises a
//                bus request into a frame for the arbiter and decodes its
//                grant/stop reply frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module master_arb_link #(
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_id,
    input  logic [1:0]            req_mode,
    input  logic                  release_req,
    output logic                  arb_out,
    input  logic                  arb_in,
    output logic                  busy,
    output logic                  granted,
    output logic                  preempted,
    output logic                  released
);

    localparam int c_FRAME_LEN = 3 + S_ID_WIDTH;
    localparam int c_SHIFT_W   = c_FRAME_LEN - 1;
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_FRAME_LEN - 1);

    localparam logic [1:0] c_CMD_GRANT = 2'b01;
    localparam logic [1:0] c_CMD_STOP  = 2'b10;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_SEND_REQ   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_GRANT = 3'd2;
    localparam logic [2:0] c_ST_GRANTED    = 3'd3;
    localparam logic [2:0] c_ST_SEND_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [c_SHIFT_W-1:0] r_tx_shift;
    logic [c_CNT_W-1:0]   r_tx_cnt;
    logic                 r_arb_out;
    logic                 r_busy;
    logic                 r_granted;
    logic                 r_preempted;
    logic                 r_released;

    logic                 r_rx_active;
    logic                 r_rx_cnt;
    logic [1:0]           r_rx_cmd;

    logic                 w_rx_run;
    logic                 w_rx_done;
    logic [1:0]           w_rx_cmd;
    logic                 w_got_grant;
    logic                 w_got_stop;
    logic                 w_tx_last;
    logic [c_SHIFT_W-1:0] w_tx_next;

    assign w_rx_run    = (r_state == c_ST_WAIT_GRANT) || (r_state == c_ST_GRANTED);
    assign w_rx_done   = r_rx_active && r_rx_cnt;
    assign w_rx_cmd    = {r_rx_cmd[0], arb_in};
    assign w_got_grant = w_rx_done && (w_rx_cmd == c_CMD_GRANT);
    assign w_got_stop  = w_rx_done && (w_rx_cmd == c_CMD_STOP);
    assign w_tx_last   = (r_tx_cnt == '0);
    assign w_tx_next   = {r_tx_shift[c_SHIFT_W-2:0], 1'b0};

    // Reply receiver: a 1 on an idle line starts a frame, then two cmd bits.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rx_active <= 1'b0;
            r_rx_cnt    <= 1'b0;
            r_rx_cmd    <= 2'b00;
        end else if (!w_rx_run) begin
            r_rx_active <= 1'b0;
            r_rx_cnt    <= 1'b0;
            r_rx_cmd    <= 2'b00;
        end else if (r_rx_active) begin
            r_rx_cmd <= w_rx_cmd;
            r_rx_cnt <= ~r_rx_cnt;
            if (r_rx_cnt) begin
                r_rx_active <= 1'b0;
            end
        end else if (arb_in) begin
            r_rx_active <= 1'b1;
            r_rx_cnt    <= 1'b0;
        end
    end

    // The start bit is driven straight onto the line at frame start; the
    // shifter only holds the bits that follow it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= c_ST_IDLE;
            r_tx_shift  <= '0;
            r_tx_cnt    <= '0;
            r_arb_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_granted   <= 1'b0;
            r_preempted <= 1'b0;
            r_released  <= 1'b0;
        end else begin
            r_preempted <= 1'b0;
            r_released  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req && (req_id != '0)) begin
                        r_state    <= c_ST_SEND_REQ;
                        r_tx_shift <= {req_id, req_mode};
                        r_tx_cnt   <= c_CNT_LOAD;
                        r_arb_out  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                c_ST_SEND_REQ: begin
                    if (w_tx_last) begin
                        r_arb_out <= 1'b0;
                        r_state   <= c_ST_WAIT_GRANT;
                    end else begin
                        r_arb_out  <= r_tx_shift[c_SHIFT_W-1];
                        r_tx_shift <= w_tx_next;
                        r_tx_cnt   <= r_tx_cnt - 1'b1;
                    end
                end
                c_ST_WAIT_GRANT: begin
                    if (w_got_grant) begin
                        r_state   <= c_ST_GRANTED;
                        r_granted <= 1'b1;
                    end
                end
                c_ST_GRANTED: begin
                    // Release takes priority over a STOP completing this cycle.
                    if (release_req) begin
                        r_state    <= c_ST_SEND_DONE;
                        r_granted  <= 1'b0;
                        r_arb_out  <= 1'b1;
                        r_tx_shift <= '0;
                        r_tx_cnt   <= c_CNT_LOAD;
                    end else if (w_got_stop) begin
                        r_state     <= c_ST_WAIT_GRANT;
                        r_granted   <= 1'b0;
                        r_preempted <= 1'b1;
                    end
                end
                c_ST_SEND_DONE: begin
                    if (w_tx_last) begin
                        r_arb_out  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_released <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_arb_out  <= r_tx_shift[c_SHIFT_W-1];
                        r_tx_shift <= w_tx_next;
                        r_tx_cnt   <= r_tx_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign arb_out   = r_arb_out;
    assign busy      = r_busy;
    assign granted   = r_granted;
    assign preempted = r_preempted;
    assign released  = r_released;

endmodule
`default_nettype wire
